keypad_entry: RTL and testbench

//  Scans the 4x4 Pmod keypad, debounces it, and builds a 4-digit player guess (one nibble per digit).

---
 rtl/keypad_entry_pkg.sv | 42 ++++
 rtl/keypad_entry_scanner.sv | 166 ++++++++++++++++
 rtl/keypad_entry.sv | 73 +++++++
 tb/tb_keypad_entry.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: key codes, scan result encoding,
// debounce states and the physical keymap.
package keypad_entry_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;

    localparam logic [3:0] KEY_BKSP = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    // Scan results are 5 bits: bit 4 set means no single key was seen.
    localparam logic [4:0] SCAN_NONE = 5'h10;

    typedef enum logic {
        RELEASED,
        PRESSED
    } DebounceState;

    // Key code printed on the keypad at (row, column).
    function automatic logic [3:0] keyMap(input logic [1:0] rowIdx, input logic [1:0] colIdx);
        logic [3:0] code;
        case ({rowIdx, colIdx})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Column scanner for the 4x4 keypad: synchronises the rows, walks the columns,
// decodes one full scan into a key code (or none) and debounces press/release.
module keypad_scanner
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);

    logic [3:0]       rowMeta;
    logic [3:0]       rowSync;
    logic [DIV_W-1:0] divCnt;
    logic [1:0]       colIdx;
    logic             slotLast;
    logic [1:0]       hitCount;
    logic [3:0]       hitCode;
    logic [1:0]       slotHits;
    logic [3:0]       slotCode;
    logic [1:0]       totalHits;
    logic [3:0]       totalCode;
    logic [4:0]       scanResult;
    logic             scanDone;

    DebounceState     state;
    DebounceState     nextState;
    logic [3:0]       candCode;
    logic [3:0]       nextCand;
    logic [DEB_W-1:0] stableCnt;
    logic [DEB_W-1:0] nextCnt;
    logic             accept;

    assign slotLast   = (divCnt == DIV_LAST);
    assign col        = ~(4'b0001 << colIdx);
    assign key_code   = scanResult[3:0];
    assign key_strobe = accept;

    // Two-flop synchroniser for the asynchronous row inputs (idle rows read high).
    always_ff @(posedge clk) begin
        if (!rst) begin
            rowMeta <= 4'hF;
            rowSync <= 4'hF;
        end else begin
            rowMeta <= row;
            rowSync <= rowMeta;
        end
    end

    // Count low rows in the current column and fold them into the running scan tally; 2 means ghost.
    always_comb begin
        slotHits  = 2'd0;
        slotCode  = 4'h0;
        totalHits = hitCount;
        totalCode = hitCode;
        for (int r = 0; r < 4; r++) begin
            if (!rowSync[r]) begin
                if (slotHits == 2'd0) begin
                    slotCode = keyMap(2'(r), colIdx);
                end
                if (slotHits != 2'd2) begin
                    slotHits = slotHits + 2'd1;
                end
            end
        end
        if (slotHits == 2'd1 && hitCount == 2'd0) begin
            totalHits = 2'd1;
            totalCode = slotCode;
        end else if (slotHits != 2'd0) begin
            totalHits = 2'd2;
        end
    end

    // Slot timer, column pointer and the per-scan result register with its one-cycle done flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            divCnt     <= '0;
            colIdx     <= 2'd0;
            hitCount   <= 2'd0;
            hitCode    <= 4'h0;
            scanResult <= SCAN_NONE;
            scanDone   <= 1'b0;
        end else begin
            scanDone <= 1'b0;
            if (slotLast) begin
                divCnt <= '0;
                colIdx <= colIdx + 2'd1;
                if (colIdx == 2'd3) begin
                    hitCount   <= 2'd0;
                    hitCode    <= 4'h0;
                    scanDone   <= 1'b1;
                    scanResult <= (totalHits == 2'd1) ? {1'b0, totalCode} : SCAN_NONE;
                end else begin
                    hitCount <= totalHits;
                    hitCode  <= totalCode;
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RELEASED;
            candCode  <= 4'h0;
            stableCnt <= '0;
        end else begin
            state     <= nextState;
            candCode  <= nextCand;
            stableCnt <= nextCnt;
        end
    end

    // Debounce decisions once per completed scan: a stable code fires once, a stable release re-arms.
    always_comb begin
        nextState = state;
        nextCand  = candCode;
        nextCnt   = stableCnt;
        accept    = 1'b0;
        if (scanDone) begin
            case (state)
                RELEASED: begin
                    if (scanResult == SCAN_NONE) begin
                        nextCnt = '0;
                    end else begin
                        if (stableCnt != '0 && scanResult[3:0] == candCode) begin
                            nextCnt = stableCnt + DEB_W'(1);
                        end else begin
                            nextCand = scanResult[3:0];
                            nextCnt  = DEB_W'(1);
                        end
                        if (nextCnt == DEB_TARGET) begin
                            accept    = 1'b1;
                            nextState = PRESSED;
                            nextCnt   = '0;
                        end
                    end
                end
                PRESSED: begin
                    if (scanResult == SCAN_NONE) begin
                        nextCnt = stableCnt + DEB_W'(1);
                        if (nextCnt == DEB_TARGET) begin
                            nextState = RELEASED;
                            nextCnt   = '0;
                        end
                    end else begin
                        nextCnt = '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad guess entry: scans the keypad and accumulates digits into a multi-digit
// guess, with backspace, clear and a one-cycle ready pulse on completion.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        enable,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic [2:0]  digit_count,
    output logic        value_ready
);

    localparam logic [2:0] FULL = 3'(NUM_DIGITS);

    logic [3:0] keyCode;
    logic       keyStrobe;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) scanner (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key_code   (keyCode),
        .key_strobe (keyStrobe)
    );

    // Digit accumulator; clear wins over a same-cycle key, keys are dropped while entry is disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value       <= 16'h0000;
            digit_count <= 3'd0;
            value_ready <= 1'b0;
        end else begin
            value_ready <= 1'b0;
            if (clear) begin
                value       <= 16'h0000;
                digit_count <= 3'd0;
            end else if (keyStrobe && enable) begin
                if (keyCode <= 4'd9) begin
                    if (digit_count == FULL) begin
                        value       <= {12'h000, keyCode};
                        digit_count <= 3'd1;
                        value_ready <= (FULL == 3'd1);
                    end else begin
                        value       <= {value[11:0], keyCode};
                        digit_count <= digit_count + 3'd1;
                        value_ready <= ((digit_count + 3'd1) == FULL);
                    end
                end else if (keyCode == KEY_BKSP) begin
                    if (digit_count != 3'd0 && digit_count != FULL) begin
                        value       <= {4'h0, value[15:4]};
                        digit_count <= digit_count - 3'd1;
                    end
                end else if (keyCode == KEY_CLR) begin
                    value       <= 16'h0000;
                    digit_count <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry with a keypad pin model and a digit-list
// reference model of the entry rules.
module tb_keypad_entry;

    localparam int SCAN_DIV    = 4;
    localparam int DEB         = 2;
    localparam int NDIG        = 4;
    localparam int SCAN_CYCLES = 4 * SCAN_DIV;
    localparam int HOLD        = 5 * SCAN_CYCLES;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  col;
    logic [15:0] value;
    logic [2:0]  digit_count;
    logic        value_ready;

    logic pressed [16];
    int   keyAt [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    int checkCount = 0;
    int passCount  = 0;
    int readyCycles = 0;
    int readyBad    = 0;
    int modelDigits[$];
    int modelReady = 0;

    always #5 clk = ~clk;

    keypad_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .NUM_DIGITS     (NDIG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .enable      (enable),
        .clear       (clear),
        .col         (col),
        .value       (value),
        .digit_count (digit_count),
        .value_ready (value_ready)
    );

    // Keypad pins: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    // Tally ready cycles, and those where the entry was not full.
    always @(negedge clk) begin
        if (rst && value_ready) begin
            readyCycles++;
            if (digit_count != 3'(NDIG)) begin
                readyBad++;
            end
        end
    end

    function automatic void modelAccept(input int key);
        if (key <= 9) begin
            if (modelDigits.size() == NDIG) begin
                modelDigits.delete();
            end
            modelDigits.push_back(key);
            if (modelDigits.size() == NDIG) begin
                modelReady++;
            end
        end else if (key == 11) begin
            if (modelDigits.size() > 0 && modelDigits.size() < NDIG) begin
                void'(modelDigits.pop_back());
            end
        end else if (key == 12) begin
            modelDigits.delete();
        end
    endfunction

    function automatic logic [15:0] modelValue();
        logic [15:0] v;
        v = 16'h0000;
        foreach (modelDigits[i]) begin
            v = {v[11:0], 4'(modelDigits[i])};
        end
        return v;
    endfunction

    function automatic int keyIndex(input int key);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (keyAt[i] == key) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    task automatic pressKey(input int key);
        int idx;
        idx = keyIndex(key);
        pressed[idx] = 1'b1;
        repeat (HOLD) @(negedge clk);
        pressed[idx] = 1'b0;
        repeat (HOLD) @(negedge clk);
        if (enable) begin
            modelAccept(key);
        end
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelDigits.delete();
    endtask

    task automatic test_reset();
        logic [3:0] expCol;
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (col !== 4'b1110) $display("[TB] FAIL reset_col: got %b expected 1110", col); else passCount++;
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL reset_value: got %h expected 0000", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", digit_count); else passCount++;
        checkCount++;
        if (value_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", value_ready); else passCount++;
        rst = 1'b1;
        for (int k = 0; k < 4 * SCAN_CYCLES / 2; k++) begin
            expCol = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            checkCount++;
            if (col !== expCol) $display("[TB] FAIL scan_col: cycle %0d got %b expected %b", k, col, expCol); else passCount++;
            @(negedge clk);
        end
    endtask

    task automatic test_sequence();
        int keys [4] = '{1, 2, 3, 4};
        foreach (keys[i]) begin
            pressKey(keys[i]);
            checkCount++;
            if (value !== modelValue()) $display("[TB] FAIL seq_value: got %h expected %h", value, modelValue()); else passCount++;
        end
        checkCount++;
        if (value !== 16'h1234) $display("[TB] FAIL seq_final: got %h expected 1234", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd4) $display("[TB] FAIL seq_count: got %0d expected 4", digit_count); else passCount++;
        checkCount++;
        if (readyCycles !== 1) $display("[TB] FAIL seq_ready: got %0d pulses expected 1", readyCycles); else passCount++;
    endtask

    task automatic test_bounce();
        int idx;
        idx = keyIndex(7);
        for (int i = 0; i < 5; i++) begin
            pressed[idx] = (i % 2 == 0);
            repeat (SCAN_CYCLES) @(negedge clk);
        end
        pressed[idx] = 1'b1;
        repeat (3 * SCAN_CYCLES) @(negedge clk);
        pressed[idx] = 1'b0;
        repeat (HOLD) @(negedge clk);
        modelAccept(7);
        checkCount++;
        if (value !== 16'h0007) $display("[TB] FAIL bounce_value: got %h expected 0007", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd1) $display("[TB] FAIL bounce_count: got %0d expected 1", digit_count); else passCount++;
    endtask

    task automatic test_backspace();
        int keys [4] = '{5, 6, 11, 9};
        int ready0;
        pulseClear();
        ready0 = readyCycles;
        foreach (keys[i]) begin
            pressKey(keys[i]);
            checkCount++;
            if (value !== modelValue()) $display("[TB] FAIL bksp_value: step %0d got %h expected %h", i, value, modelValue()); else passCount++;
            checkCount++;
            if (digit_count !== 3'(modelDigits.size())) $display("[TB] FAIL bksp_count: step %0d got %0d expected %0d", i, digit_count, modelDigits.size()); else passCount++;
        end
        checkCount++;
        if (value !== 16'h0059) $display("[TB] FAIL bksp_final: got %h expected 0059", value); else passCount++;
        checkCount++;
        if (readyCycles !== ready0) $display("[TB] FAIL bksp_ready: got %0d pulses expected %0d", readyCycles, ready0); else passCount++;
    endtask

    task automatic test_new_entry();
        int keys [5] = '{1, 2, 3, 4, 8};
        pulseClear();
        foreach (keys[i]) pressKey(keys[i]);
        checkCount++;
        if (value !== 16'h0008) $display("[TB] FAIL newentry_value: got %h expected 0008", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd1) $display("[TB] FAIL newentry_count: got %0d expected 1", digit_count); else passCount++;
        checkCount++;
        if (readyCycles !== modelReady) $display("[TB] FAIL newentry_ready: got %0d pulses expected %0d", readyCycles, modelReady); else passCount++;
    endtask

    task automatic test_enable_clear();
        int idx;
        bit seen;
        idx = keyIndex(3);
        enable = 1'b0;
        pressed[idx] = 1'b1;
        repeat (HOLD) @(negedge clk);
        enable = 1'b1;
        repeat (HOLD) @(negedge clk);
        pressed[idx] = 1'b0;
        repeat (HOLD) @(negedge clk);
        checkCount++;
        if (value !== modelValue()) $display("[TB] FAIL disabled_value: got %h expected %h", value, modelValue()); else passCount++;
        checkCount++;
        if (digit_count !== 3'(modelDigits.size())) $display("[TB] FAIL disabled_count: got %0d expected %0d", digit_count, modelDigits.size()); else passCount++;
        idx = keyIndex(5);
        pressed[idx] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 * SCAN_CYCLES && !seen; i++) begin
            @(negedge clk);
            if (dut.keyStrobe) begin
                seen = 1'b1;
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        end
        modelDigits.delete();
        checkCount++;
        if (!seen) $display("[TB] FAIL clear_sync: got no accept expected one within %0d cycles", 20 * SCAN_CYCLES); else passCount++;
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL clear_value: got %h expected 0000", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd0) $display("[TB] FAIL clear_count: got %0d expected 0", digit_count); else passCount++;
        pressed[idx] = 1'b0;
        repeat (HOLD) @(negedge clk);
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL clear_after: got %h expected 0000", value); else passCount++;
    endtask

    task automatic test_ghost_reset();
        int idxA;
        int idxB;
        idxA = keyIndex(2);
        idxB = keyIndex(5);
        pressed[idxA] = 1'b1;
        pressed[idxB] = 1'b1;
        repeat (HOLD) @(negedge clk);
        pressed[idxA] = 1'b0;
        pressed[idxB] = 1'b0;
        repeat (HOLD) @(negedge clk);
        checkCount++;
        if (value !== modelValue()) $display("[TB] FAIL ghost_value: got %h expected %h", value, modelValue()); else passCount++;
        checkCount++;
        if (digit_count !== 3'(modelDigits.size())) $display("[TB] FAIL ghost_count: got %0d expected %0d", digit_count, modelDigits.size()); else passCount++;
        pressKey(6);
        idxA = keyIndex(4);
        pressed[idxA] = 1'b1;
        repeat ($urandom_range(3, SCAN_CYCLES)) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (col !== 4'b1110) $display("[TB] FAIL midreset_col: got %b expected 1110", col); else passCount++;
        checkCount++;
        if (value !== 16'h0000) $display("[TB] FAIL midreset_value: got %h expected 0000", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd0) $display("[TB] FAIL midreset_count: got %0d expected 0", digit_count); else passCount++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        modelDigits.delete();
        repeat (HOLD) @(negedge clk);
        pressed[idxA] = 1'b0;
        repeat (HOLD) @(negedge clk);
        modelAccept(4);
        checkCount++;
        if (value !== 16'h0004) $display("[TB] FAIL heldreset_value: got %h expected 0004", value); else passCount++;
        checkCount++;
        if (digit_count !== 3'd1) $display("[TB] FAIL heldreset_count: got %0d expected 1", digit_count); else passCount++;
    endtask

    task automatic test_random();
        int key;
        for (int i = 0; i < 24; i++) begin
            key = int'($urandom_range(0, 15));
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pulseClear();
            end
            pressKey(key);
            checkCount++;
            if (value !== modelValue()) $display("[TB] FAIL rand_value: key %h en %b got %h expected %h", key, enable, value, modelValue()); else passCount++;
            checkCount++;
            if (digit_count !== 3'(modelDigits.size())) $display("[TB] FAIL rand_count: key %h got %0d expected %0d", key, digit_count, modelDigits.size()); else passCount++;
        end
        enable = 1'b1;
        checkCount++;
        if (readyCycles !== modelReady) $display("[TB] FAIL rand_ready: got %0d pulses expected %0d", readyCycles, modelReady); else passCount++;
        checkCount++;
        if (readyBad !== 0) $display("[TB] FAIL ready_when_not_full: got %0d cycles expected 0", readyBad); else passCount++;
    endtask

    // Scenario sequence.
    initial begin
        foreach (pressed[i]) pressed[i] = 1'b0;
        $display("[TB] keypad_entry bench start");
        test_reset();
        test_sequence();
        test_bounce();
        test_backspace();
        test_new_entry();
        test_enable_clear();
        test_ghost_reset();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
